// File: rtl/i2c_pad_bank.sv
// Open-drain pad front-end for NCH I2C master channels: synchronising glitch filter,
// START/STOP bus-busy tracking and a per-channel stuck-bus recovery engine.

module i2c_pad_filt #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);
   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // filt follows sync[1] only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= 2'b11;
         cnt  <= '0;
         filt <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CMAX) begin
            filt <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module i2c_pad_ch #(
   parameter int FILT_LEN = 3,
   parameter int HALF_PER = 250,
   parameter int PULSES   = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic m_scl_o,
   input  logic m_scl_oen,
   input  logic m_sda_o,
   input  logic m_sda_oen,
   output logic m_scl_i,
   output logic m_sda_i,
   input  logic pad_scl_in,
   input  logic pad_sda_in,
   output logic pad_scl_oeb,
   output logic pad_sda_oeb,
   input  logic recover,
   output logic busy,
   output logic recovering,
   output logic rec_done,
   output logic rec_fail
);
   localparam int HW = $clog2(HALF_PER);
   localparam int PW = $clog2(PULSES + 1);
   localparam logic [HW-1:0] HP_LD = HW'(HALF_PER - 1);
   localparam logic [PW-1:0] PMAX  = PW'(PULSES);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, S_LO, S_SU, S_HI, DONE} st_t;

   st_t           st;
   logic [HW-1:0] hp;
   logic [PW-1:0] pcnt;
   logic          rel_scl, rel_sda;
   logic          scl_f, sda_f, sda_q;
   logic          hp_end;

   i2c_pad_filt #(.FILT_LEN(FILT_LEN)) u_scl (.clk(clk), .rst_n(rst_n), .raw(pad_scl_in), .filt(scl_f));
   i2c_pad_filt #(.FILT_LEN(FILT_LEN)) u_sda (.clk(clk), .rst_n(rst_n), .raw(pad_sda_in), .filt(sda_f));

   assign m_scl_i     = scl_f;
   assign m_sda_i     = sda_f;
   assign hp_end      = (hp == '0);
   assign pad_scl_oeb = (st == IDLE) ? ~(m_scl_oen & ~m_scl_o) : rel_scl;
   assign pad_sda_oeb = (st == IDLE) ? ~(m_sda_oen & ~m_sda_o) : rel_sda;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sda_q <= 1'b1;
         busy  <= 1'b0;
      end else begin
         sda_q <= sda_f;
         if (scl_f && sda_q && !sda_f)
            busy <= 1'b1;
         else if (scl_f && !sda_q && sda_f)
            busy <= 1'b0;
      end
   end

   // hp reloads on every state entry; in HIGH it only runs while SCL is seen high (stretching)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= IDLE;
         hp         <= HP_LD;
         pcnt       <= '0;
         rel_scl    <= 1'b1;
         rel_sda    <= 1'b1;
         recovering <= 1'b0;
         rec_done   <= 1'b0;
         rec_fail   <= 1'b0;
      end else begin
         rec_done <= 1'b0;
         case (st)
            IDLE: if (recover) begin
               st         <= LOW;
               hp         <= HP_LD;
               pcnt       <= '0;
               rec_fail   <= 1'b0;
               recovering <= 1'b1;
               rel_scl    <= 1'b0;
               rel_sda    <= 1'b1;
            end
            LOW: if (hp_end) begin
               st      <= HIGH;
               hp      <= HP_LD;
               pcnt    <= pcnt + 1'b1;
               rel_scl <= 1'b1;
            end else hp <= hp - 1'b1;
            HIGH: if (scl_f) begin
               if (hp_end) begin
                  hp <= HP_LD;
                  if (sda_f) begin
                     st      <= S_LO;
                     rel_scl <= 1'b0;
                     rel_sda <= 1'b0;
                  end else if (pcnt == PMAX) begin
                     st         <= DONE;
                     rec_fail   <= 1'b1;
                     rec_done   <= 1'b1;
                     recovering <= 1'b0;
                  end else begin
                     st      <= LOW;
                     rel_scl <= 1'b0;
                  end
               end else hp <= hp - 1'b1;
            end
            S_LO: if (hp_end) begin
               st      <= S_SU;
               hp      <= HP_LD;
               rel_scl <= 1'b1;
            end else hp <= hp - 1'b1;
            S_SU: if (hp_end) begin
               st      <= S_HI;
               hp      <= HP_LD;
               rel_sda <= 1'b1;
            end else hp <= hp - 1'b1;
            S_HI: if (hp_end) begin
               st         <= DONE;
               hp         <= HP_LD;
               rec_done   <= 1'b1;
               recovering <= 1'b0;
            end else hp <= hp - 1'b1;
            DONE: st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end
endmodule

module i2c_pad_bank #(
   parameter int NCH      = 2,
   parameter int FILT_LEN = 3,
   parameter int HALF_PER = 250,
   parameter int PULSES   = 9
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_n,
   input  logic [NCH-1:0] m_scl_o,
   input  logic [NCH-1:0] m_scl_oen,
   input  logic [NCH-1:0] m_sda_o,
   input  logic [NCH-1:0] m_sda_oen,
   output logic [NCH-1:0] m_scl_i,
   output logic [NCH-1:0] m_sda_i,
   input  logic [NCH-1:0] pad_scl_in,
   input  logic [NCH-1:0] pad_sda_in,
   output logic [NCH-1:0] pad_scl_out,
   output logic [NCH-1:0] pad_sda_out,
   output logic [NCH-1:0] pad_scl_oeb,
   output logic [NCH-1:0] pad_sda_oeb,
   input  logic [NCH-1:0] recover_i,
   output logic [NCH-1:0] busy_o,
   output logic [NCH-1:0] recovering_o,
   output logic [NCH-1:0] rec_done_o,
   output logic [NCH-1:0] rec_fail_o,
   output logic           irq_o
);
   assign pad_scl_out = '0;
   assign pad_sda_out = '0;
   assign irq_o       = |rec_done_o;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      i2c_pad_ch #(.FILT_LEN(FILT_LEN), .HALF_PER(HALF_PER), .PULSES(PULSES)) u_ch (
         .clk(wb_clk_i), .rst_n(wb_rst_n),
         .m_scl_o(m_scl_o[g]), .m_scl_oen(m_scl_oen[g]),
         .m_sda_o(m_sda_o[g]), .m_sda_oen(m_sda_oen[g]),
         .m_scl_i(m_scl_i[g]), .m_sda_i(m_sda_i[g]),
         .pad_scl_in(pad_scl_in[g]), .pad_sda_in(pad_sda_in[g]),
         .pad_scl_oeb(pad_scl_oeb[g]), .pad_sda_oeb(pad_sda_oeb[g]),
         .recover(recover_i[g]), .busy(busy_o[g]), .recovering(recovering_o[g]),
         .rec_done(rec_done_o[g]), .rec_fail(rec_fail_o[g])
      );
   end
endmodule
